// File: rtl/mux_pkg.sv
// mux_pkg: shared mode encodings and select-width helper for mux_scan_sel
package mux_pkg;
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN = 1'b1;
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/scan_timer.sv
// scan_timer: DWELL-modulo dwell counter with clear, enable and terminal count
module scan_timer #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);
  localparam logic [7:0] TC_V = 8'(DWELL - 1);
  logic [7:0] cnt_q, cnt_d;
  always_comb begin
    tc = cnt_q == TC_V;
    cnt_d = clr ? '0 : en ? (tc ? '0 : cnt_q + 8'd1) : cnt_q;
  end
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/mux_scan_sel.sv
// mux_scan_sel: N-channel registered mux with manual select and auto-scan
module mux_scan_sel
  import mux_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int NCH = 4,
  parameter int SELW = 2,
  parameter int DWELL = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] din,
  input  logic                 en,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel_in,
  input  logic                 sel_load,
  output logic [WIDTH-1:0]     dout,
  output logic [SELW-1:0]      ch_out,
  output logic                 dout_valid,
  output logic                 wrap
);
  if (SELW != clog2(NCH) || NCH < 2 || NCH > 16 || DWELL < 1 || DWELL > 255) begin : g_bad_cfg
    $error("mux_scan_sel: illegal NCH/SELW/DWELL combination");
  end
  localparam logic [SELW:0] NCH_L = (SELW + 1)'(NCH);
  localparam logic [SELW-1:0] LAST = SELW'(NCH - 1);
  logic [WIDTH-1:0] chan [NCH];
  for (genvar k = 0; k < NCH; k++) begin : g_chan
    assign chan[k] = din[k*WIDTH +: WIDTH];
  end
  logic [SELW-1:0] sel_q, sel_d, ch_q, ch_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic vld_q, vld_d, wrap_q, wrap_d;
  logic ld, scan, adv, last, tc, tmr_en, tmr_clr;
  scan_timer #(.DWELL(DWELL)) u_timer (
    .clk(clk),
    .rst(rst),
    .en(tmr_en),
    .clr(tmr_clr),
    .tc(tc)
  );
  // a valid load outranks the terminal count, so it also suppresses advance and wrap
  always_comb begin
    ld = sel_load && ({1'b0, sel_in} < NCH_L);
    scan = mode == MODE_SCAN;
    tmr_en = en && scan && !ld;
    tmr_clr = en && (ld || !scan);
    adv = tmr_en && tc;
    last = sel_q == LAST;
    sel_d = !en ? sel_q : ld ? sel_in : adv ? (last ? '0 : sel_q + SELW'(1)) : sel_q;
    dout_d = en ? chan[sel_q] : dout_q;
    ch_d = en ? sel_q : ch_q;
    vld_d = en;
    wrap_d = adv && last;
  end
  always_ff @(posedge clk)
    if (rst) begin
      sel_q <= '0;
      dout_q <= '0;
      ch_q <= '0;
      vld_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      sel_q <= sel_d;
      dout_q <= dout_d;
      ch_q <= ch_d;
      vld_q <= vld_d;
      wrap_q <= wrap_d;
    end
  assign dout = dout_q;
  assign ch_out = ch_q;
  assign dout_valid = vld_q;
  assign wrap = wrap_q;
endmodule
